rssb_core: RTL and testbench

- Single-instruction RSSB (reverse-subtract, skip-if-borrow) execution engine.
- It is the initiator/master on the word-wide memory bus that the RAM block serves: it drives address, write data and write strobe, and consumes combinational read data.
- Each instruction is one operand address `a`. The engine computes `acc = M[a] - acc`, writes the result back to `M[a]`, and skips the next instruction on borrow.
- Sits between the top-level run control and the RAM/register-file instance.

---
 rtl/rssb_core.sv | 120 ++++++++++++
 tb/tb_rssb_core.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rssb_core.sv
// RSSB execution engine: acc = M[a] - acc, write back, skip next on borrow.
// Define RSSB_STEP_EN to add a single-step input that gates each instruction fetch.
module rssb_core #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] RESET_PC = 8'h80,
    parameter logic [WIDTH-1:0] HALT_OP  = 8'hFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
`ifdef RSSB_STEP_EN
    input  logic             step,
`endif
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_write,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] pc,
    output logic             halted
);

    typedef enum logic [1:0] {StFetch, StRead, StExec, StHalt} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] mdr_q, mdr_d;
    logic             go;

`ifdef RSSB_STEP_EN
    logic step_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) step_q <= 1'b0;
        else      step_q <= step;
    end

    // One instruction per rising edge of step; a held level does not repeat.
    assign go = run & step & ~step_q;
`else
    assign go = run;
`endif

    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ir_is0, ir_is1;
    logic [WIDTH-1:0] pc_next;

    assign diff    = mdr_q - acc_q;
    assign borrow  = mdr_q < acc_q;
    assign ir_is0  = (ir_q == '0);
    assign ir_is1  = (ir_q == WIDTH'(1));
    assign pc_next = pc_q + WIDTH'(1) + {{(WIDTH-1){1'b0}}, borrow};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            acc_q   <= '0;
            ir_q    <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        acc_d     = acc_q;
        ir_d      = ir_q;
        mdr_d     = mdr_q;
        mem_addr  = pc_q;
        mem_wdata = '0;
        mem_write = 1'b0;
        halted    = 1'b0;
        case (state_q)
            StFetch: begin
                if (run && mem_rdata == HALT_OP) begin
                    state_d = StHalt;
                end else if (go) begin
                    ir_d    = mem_rdata;
                    state_d = StRead;
                end
            end
            StRead: begin
                mem_addr = ir_q;
                // Addresses 0 and 1 alias PC and ACC rather than memory.
                if (ir_is0)      mdr_d = pc_q;
                else if (ir_is1) mdr_d = acc_q;
                else             mdr_d = mem_rdata;
                state_d = StExec;
            end
            StExec: begin
                mem_addr  = ir_q;
                mem_wdata = diff;
                mem_write = !ir_is0 && !ir_is1;
                acc_d     = diff;
                pc_d      = ir_is0 ? diff : pc_next;
                state_d   = StFetch;
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    assign acc = acc_q;
    assign pc  = pc_q;

endmodule

// File: tb/tb_rssb_core.sv
// Scoreboard bench for rssb_core: expected memory writes are queued by the stimulus
// thread and checked by a forked bus monitor; architectural state is checked directly.
module tb_rssb_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b1;
    logic [7:0] mem_addr, mem_wdata, mem_rdata, acc, pc;
    logic       mem_write, halted;
`ifdef RSSB_STEP_EN
    logic       step = 1'b0;
`endif

    always #5 clk = ~clk;

    rssb_core #(.WIDTH(8), .RESET_PC(8'h80), .HALT_OP(8'hFF)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
`ifdef RSSB_STEP_EN
        .step      (step),
`endif
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata),
        .acc       (acc),
        .pc        (pc),
        .halted    (halted)
    );

    // Memory model: program loads and bus writes share one process.
    logic [7:0] mem [256];
    logic       ld_en   = 1'b0;
    logic [7:0] ld_addr = 8'h00;
    logic [7:0] ld_data = 8'h00;

    always @(posedge clk) begin
        if (ld_en)          mem[ld_addr] <= ld_data;
        else if (mem_write) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  wr_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic monitor();
        logic prev_wr;
        wr_t  e;
        prev_wr = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_write) begin
                wr_seen++;
                chk("wr_not_back_to_back", {31'd0, prev_wr}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {24'd0, mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", {24'd0, mem_addr}, {24'd0, e.addr});
                    chk("wr_data", {24'd0, mem_wdata}, {24'd0, e.data});
                end
            end
            prev_wr = mem_write;
        end
    endtask

    initial begin
        wr_seen = 0;
        fork
            monitor();
        join_none

        tick(2);
        chk("rst_pc", {24'd0, pc}, 32'h80);
        chk("rst_acc", {24'd0, acc}, 32'h00);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 32'h80);
        chk("rst_halted", {31'd0, halted}, 32'd0);

`ifdef RSSB_STEP_EN
        poke(8'h80, 8'h84);
        poke(8'h84, 8'h05);
        exp_q.push_back('{addr: 8'h84, data: 8'h05});
        rst = 1'b1;
        tick(5);
        chk("step_idle_pc", {24'd0, pc}, 32'h80);
        step = 1'b1;
        tick(10);
        chk("step_one_pc", {24'd0, pc}, 32'h81);
        chk("step_one_acc", {24'd0, acc}, 32'h05);
        chk("step_one_write", wr_seen, 32'd1);
        step = 1'b0;
`else
        // Basic subtract, then a borrowing subtract that skips.
        poke(8'h80, 8'h84);
        poke(8'h84, 8'h05);
        poke(8'h81, 8'h85);
        poke(8'h85, 8'h03);
        poke(8'h83, 8'h88);
        poke(8'h88, 8'h01);
        exp_q.push_back('{addr: 8'h84, data: 8'h05});
        exp_q.push_back('{addr: 8'h85, data: 8'hFE});
        exp_q.push_back('{addr: 8'h88, data: 8'h03});
        rst = 1'b1;
        tick(3);
        chk("sub_pc", {24'd0, pc}, 32'h81);
        chk("sub_acc", {24'd0, acc}, 32'h05);
        chk("sub_mem", {24'd0, mem[8'h84]}, 32'h05);
        tick(3);
        chk("skip_pc", {24'd0, pc}, 32'h83);
        chk("skip_acc", {24'd0, acc}, 32'hFE);
        chk("skip_mem", {24'd0, mem[8'h85]}, 32'hFE);
        chk("two_writes", wr_seen, 32'd2);

        run = 1'b0;
        tick(10);
        chk("stall_pc", {24'd0, pc}, 32'h83);
        chk("stall_acc", {24'd0, acc}, 32'hFE);
        chk("stall_addr", {24'd0, mem_addr}, 32'h83);

        // Reset dropped in EXEC must kill the write strobe without a clock edge.
        run = 1'b1;
        tick(2);
        chk("exec_write", {31'd0, mem_write}, 32'd1);
        chk("exec_addr", {24'd0, mem_addr}, 32'h88);
        #2 rst = 1'b0;
        #1;
        chk("async_write", {31'd0, mem_write}, 32'd0);
        chk("async_pc", {24'd0, pc}, 32'h80);
        chk("async_acc", {24'd0, acc}, 32'h00);
        chk("async_addr", {24'd0, mem_addr}, 32'h80);
        tick(1);
        chk("async_no_store", {24'd0, mem[8'h88]}, 32'h01);

        // Jump through address 0, then halt at the target.
        poke(8'h80, 8'h87);
        poke(8'h87, 8'h00);
        poke(8'h81, 8'h86);
        poke(8'h86, 8'h10);
        poke(8'h82, 8'h00);
        poke(8'h72, 8'hFF);
        exp_q.push_back('{addr: 8'h87, data: 8'h00});
        exp_q.push_back('{addr: 8'h86, data: 8'h10});
        wr_seen = 0;
        rst = 1'b1;
        tick(6);
        chk("pre_jump_pc", {24'd0, pc}, 32'h82);
        chk("pre_jump_acc", {24'd0, acc}, 32'h10);
        tick(3);
        chk("jump_pc", {24'd0, pc}, 32'h72);
        chk("jump_acc", {24'd0, acc}, 32'h72);
        chk("jump_writes", wr_seen, 32'd2);
        tick(1);
        chk("jump_halt", {31'd0, halted}, 32'd1);
        tick(20);
        chk("halt_pc", {24'd0, pc}, 32'h72);
        chk("halt_acc", {24'd0, acc}, 32'h72);
        chk("halt_writes", wr_seen, 32'd2);

        // Halt opcode as the very first instruction.
        rst = 1'b0;
        poke(8'h80, 8'hFF);
        wr_seen = 0;
        rst = 1'b1;
        tick(2);
        chk("halt_first", {31'd0, halted}, 32'd1);
        chk("halt_first_addr", {24'd0, mem_addr}, 32'h80);
        tick(20);
        chk("halt_first_writes", wr_seen, 32'd0);
        chk("halt_first_pc", {24'd0, pc}, 32'h80);
`endif

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
